multi_ch_collision_detector: RTL
================================

MULTI_CH_COLLISION_DETECTOR -- requirements
Module: multi_ch_collision_detector

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent hit channels (paddles/targets), legal range 1..4.
REQ-002 Parameter CNT_W, default 10, width of each per-channel pixel accumulator.
REQ-003 Parameter HIT_THRESH, default 16, minimum per-frame overlap pixel count that counts as a collision.
REQ-004 Parameter COOLDOWN_FRAMES, default 8, number of frames a channel stays blind after it collides (1..255).
REQ-005 Parameter X_LAST / Y_LAST, default 639 / 479, coordinates of the last visible pixel of a frame.
REQ-006 Parameter CH_DIR, default {NUM_CH{1'b1}}, per-channel required ball direction (1 = moving right).
REQ-007 clk_25MHz  input  1  sole clock; all logic is rising-edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 x_pixel  input  10  current VGA column.
REQ-010 y_pixel  input  10  current VGA row.
REQ-011 is_hit_area  input  NUM_CH  per-channel flag: current pixel lies inside that channel's ball hit window.
REQ-012 is_target_color  input  NUM_CH  per-channel flag: current pixel matches that channel's target color.
REQ-013 ch_enable  input  NUM_CH  per-channel enable; 0 freezes the channel in reset-like state.
REQ-014 is_ball_moving_right  input  1  current ball direction.
REQ-015 collision_detected  output  NUM_CH  per-channel one-cycle collision pulse.
REQ-016 collision_any  output  1  one-cycle pulse, OR of collision_detected.
REQ-017 hit_count  output  NUM_CH*CNT_W  last completed frame's overlap count per channel, channel c at bits [c*CNT_W +: CNT_W].
REQ-018 estimated_speed  output  10  frames elapsed between the two most recent collisions on any channel.

Function
REQ-019 Overlap pixel for channel c = is_hit_area[c] & is_target_color[c] & ch_enable[c], evaluated every cycle.
REQ-020 Each channel accumulator increments by 1 per overlap pixel and saturates at 2^CNT_W-1 (no wrap).
REQ-021 EOF cycle = cycle where x_pixel==X_LAST and y_pixel==Y_LAST; the overlap pixel of the EOF cycle itself is included in that frame's total.
REQ-022 On EOF cycle: hit_count[c] is loaded with the frame total (saturated) and the accumulator clears to 0; visible on outputs the cycle after EOF.
REQ-023 Per-channel FSM states ARMED and COOLDOWN; reset and ch_enable[c]==0 force ARMED with cooldown counter 0.
REQ-024 ARMED -> COOLDOWN on EOF when frame total >= HIT_THRESH and is_ball_moving_right == CH_DIR[c] (sampled on EOF cycle); collision_detected[c] pulses high exactly one cycle, the cycle after EOF.
REQ-025 ARMED with total < HIT_THRESH or direction mismatch: stays ARMED, no pulse.
REQ-026 COOLDOWN: cooldown counter loaded with COOLDOWN_FRAMES on entry, decrements on each subsequent EOF; returns to ARMED on the EOF where it reaches 0; no pulse on any EOF while in COOLDOWN, including the returning one.
REQ-027 Simultaneous collisions on several channels at the same EOF: every such channel pulses; collision_any pulses once; speed updated once.
REQ-028 Global frame counter (10 bit) increments on every EOF, saturates at 1023.
REQ-029 On any collision pulse cycle: estimated_speed <= frame counter value, frame counter <= 0 (collision EOF counted before clear, i.e. two collisions N frames apart give N).
REQ-030 hit_count keeps updating in COOLDOWN and for enabled channels regardless of direction; disabled channels report 0.
REQ-031 No output is combinationally dependent on inputs; all outputs registered.

Reset
REQ-032 While reset is high at a clock edge: all accumulators, hit_count, cooldown counters, frame counter, estimated_speed, collision_detected and collision_any go to 0; all FSMs to ARMED.
REQ-033 Reset asserted mid-frame discards the partial frame; first possible pulse is after the first full EOF following release.
REQ-034 Reset coincident with an EOF cycle wins: no pulse, no hit_count load.

Verification
REQ-035 NUM_CH=2, ch0 20 overlap pixels in frame, direction right -> collision_detected=2'b01 one cycle after EOF, hit_count[0]=20, collision_any 1 cycle.
REQ-036 ch0 15 overlap pixels (HIT_THRESH=16) -> no pulse, hit_count[0]=15; with 16th pixel placed at (639,479) -> pulse.
REQ-037 ch0 collides frame 0, 20 pixels every following frame, COOLDOWN_FRAMES=8 -> next pulse at EOF of frame 9 only; estimated_speed=9.
REQ-038 Both channels 30 pixels same frame, CH_DIR=2'b11 -> collision_detected=2'b11, single collision_any pulse; with CH_DIR=2'b01 and ball moving left -> no pulses.
REQ-039 CNT_W=4, 100 overlap pixels -> hit_count=15, pulse if HIT_THRESH<=15.
REQ-040 Reset pulsed at pixel (320,240) after 50 overlap pixels, 10 more after release -> hit_count=10 at EOF, no pulse (HIT_THRESH=16); all outputs 0 during reset.

Source files
------------

// File: rtl/multi_ch_collision_detector.sv
// Per-channel frame overlap counter with threshold collision detection, per-channel
// cooldown, and a global frame counter measuring frames between collisions.
module multi_ch_collision_detector #(
  parameter int                NUM_CH          = 2,
  parameter int                CNT_W           = 10,
  parameter int                HIT_THRESH      = 16,
  parameter int                COOLDOWN_FRAMES = 8,
  parameter int                X_LAST          = 639,
  parameter int                Y_LAST          = 479,
  parameter logic [NUM_CH-1:0] CH_DIR          = {NUM_CH{1'b1}}
) (
  input  logic                    clk_25MHz,
  input  logic                    reset,
  input  logic [9:0]              x_pixel,
  input  logic [9:0]              y_pixel,
  input  logic [NUM_CH-1:0]       is_hit_area,
  input  logic [NUM_CH-1:0]       is_target_color,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    is_ball_moving_right,
  output logic [NUM_CH-1:0]       collision_detected,
  output logic                    collision_any,
  output logic [NUM_CH*CNT_W-1:0] hit_count,
  output logic [9:0]              estimated_speed
);

  typedef enum logic {ARMED, COOLDOWN} state_t;

  state_t            state        [NUM_CH];
  logic [7:0]        cooldown_cnt [NUM_CH];
  logic [CNT_W-1:0]  acc          [NUM_CH];
  logic [CNT_W-1:0]  total        [NUM_CH];
  logic [NUM_CH-1:0] overlap;
  logic [NUM_CH-1:0] fire;
  logic              eof;
  logic [9:0]        frame_cnt;
  logic [9:0]        frame_cnt_inc;

  assign eof           = (x_pixel == 10'(X_LAST)) && (y_pixel == 10'(Y_LAST));
  assign frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 10'd1;

  // total includes the current pixel so the EOF pixel lands in its own frame
  always_comb begin
    overlap = '0;
    fire    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      overlap[c] = is_hit_area[c] & is_target_color[c] & ch_enable[c];
      total[c]   = (acc[c] == '1) ? acc[c] : acc[c] + CNT_W'(overlap[c]);
      fire[c]    = eof && ch_enable[c] && (state[c] == ARMED) &&
                   (int'(total[c]) >= HIT_THRESH) &&
                   (is_ball_moving_right == CH_DIR[c]);
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state[c]        <= ARMED;
        cooldown_cnt[c] <= '0;
        acc[c]          <= '0;
      end
      hit_count          <= '0;
      collision_detected <= '0;
      collision_any      <= 1'b0;
      frame_cnt          <= '0;
      estimated_speed    <= '0;
    end else begin
      collision_detected <= fire;
      collision_any      <= |fire;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!ch_enable[c]) begin
          state[c]                     <= ARMED;
          cooldown_cnt[c]              <= '0;
          acc[c]                       <= '0;
          hit_count[c*CNT_W +: CNT_W]  <= '0;
        end else if (eof) begin
          acc[c]                      <= '0;
          hit_count[c*CNT_W +: CNT_W] <= total[c];
          case (state[c])
            ARMED: begin
              if (fire[c]) begin
                state[c]        <= COOLDOWN;
                cooldown_cnt[c] <= 8'(COOLDOWN_FRAMES);
              end
            end
            COOLDOWN: begin
              cooldown_cnt[c] <= cooldown_cnt[c] - 8'd1;
              if (cooldown_cnt[c] <= 8'd1) state[c] <= ARMED;
            end
            default: state[c] <= ARMED;
          endcase
        end else begin
          acc[c] <= total[c];
        end
      end
      // the collision EOF itself is counted before the counter restarts
      if (eof) begin
        if (|fire) begin
          estimated_speed <= frame_cnt_inc;
          frame_cnt       <= '0;
        end else begin
          frame_cnt <= frame_cnt_inc;
        end
      end
    end
  end

endmodule
